// File: rtl/prim_and2_chk_pkg.sv
// Shared types and constants for the redundant AND2 checker.
// State codes keep a pairwise Hamming distance of at least two.
package prim_and2_chk_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'b000,
    StSuspect = 3'b011,
    StAlert   = 3'b101,
    StLocked  = 3'b110
  } state_e;

  localparam int ErrCntW = 8;
  localparam logic [ErrCntW-1:0] ErrCntMax = 8'hFF;

endpackage

// File: rtl/prim_xilinx_and2.sv
// Plain bitwise AND2 primitive.
// Instantiated twice so each copy stays a distinct gate.
module prim_xilinx_and2 #(
  parameter int Width = 1
) (
  input  logic [Width-1:0] in0_i,
  input  logic [Width-1:0] in1_i,
  output logic [Width-1:0] out_o
);

  assign out_o = in0_i & in1_i;

endmodule

// File: rtl/prim_and2_redundancy_checker.sv
// Duplicated AND gating with mismatch counting and alert handshake.
// PRIM_AND2_CHK_FI_EN adds fi_flip_i, XORed into copy B before compare.
module prim_and2_redundancy_checker
  import prim_and2_chk_pkg::*;
#(
  parameter int Width          = 1,
  parameter int MismatchThresh = 2,
  parameter bit StickyAlert    = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [Width-1:0]   in0_i,
  input  logic [Width-1:0]   in1_i,
`ifdef PRIM_AND2_CHK_FI_EN
  input  logic [Width-1:0]   fi_flip_i,
`endif
  output logic [Width-1:0]   out_o,
  output logic               out_valid_o,
  output logic               alert_req_o,
  input  logic               alert_ack_i,
  output logic               fault_o,
  output logic [ErrCntW-1:0] err_cnt_o
);

  localparam logic [3:0] Thresh = 4'(MismatchThresh);

  (* keep = "true" *) logic [Width-1:0] r_a0;
  (* keep = "true" *) logic [Width-1:0] r_a1;
  (* keep = "true" *) logic [Width-1:0] r_b0;
  (* keep = "true" *) logic [Width-1:0] r_b1;

  logic               r_v1;
  logic               r_v2;
  logic               r_mis;
  logic [Width-1:0]   r_out;
  logic [Width-1:0]   w_and_a;
  logic [Width-1:0]   w_and_b;
  logic [Width-1:0]   w_and_b_cmp;
  logic               w_mis;
  logic               w_vmis;
  state_e             r_state;
  state_e             w_state_d;
  logic [3:0]         r_cnt;
  logic [3:0]         w_cnt_d;
  logic [ErrCntW-1:0] r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a0 <= '0;
      r_a1 <= '0;
      r_b0 <= '0;
      r_b1 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= en_i;
      if (en_i) begin
        r_a0 <= in0_i;
        r_a1 <= in1_i;
        r_b0 <= in0_i;
        r_b1 <= in1_i;
      end
    end
  end

  prim_xilinx_and2 #(.Width(Width)) u_and_a (
    .in0_i (r_a0),
    .in1_i (r_a1),
    .out_o (w_and_a)
  );

  prim_xilinx_and2 #(.Width(Width)) u_and_b (
    .in0_i (r_b0),
    .in1_i (r_b1),
    .out_o (w_and_b)
  );

`ifdef PRIM_AND2_CHK_FI_EN
  assign w_and_b_cmp = w_and_b ^ fi_flip_i;
`else
  assign w_and_b_cmp = w_and_b;
`endif

  assign w_mis  = (w_and_a != w_and_b_cmp);
  assign w_vmis = r_v2 & r_mis;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_v2  <= 1'b0;
      r_mis <= 1'b0;
      r_out <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_out <= w_and_a & {Width{~w_mis}};
        r_mis <= w_mis;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= '0;
    end else if (w_vmis && (r_err != ErrCntMax)) begin
      r_err <= r_err + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      StIdle: begin
        if (w_vmis) begin
          w_cnt_d   = 4'd1;
          w_state_d = (MismatchThresh == 1) ? StAlert : StSuspect;
        end
      end
      StSuspect: begin
        if (r_v2 && r_mis) begin
          w_cnt_d = r_cnt + 4'd1;
          if ((r_cnt + 4'd1) == Thresh) w_state_d = StAlert;
        end else if (r_v2) begin
          w_cnt_d   = '0;
          w_state_d = StIdle;
        end
      end
      StAlert: begin
        if (alert_ack_i) begin
          if (StickyAlert) begin
            w_state_d = StLocked;
          end else begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
          end
        end
      end
      StLocked: w_state_d = StLocked;
      default:  w_state_d = StAlert;
    endcase
  end

  always_comb begin
    alert_req_o = 1'b0;
    fault_o     = 1'b0;
    case (r_state)
      StAlert: begin
        alert_req_o = 1'b1;
        fault_o     = 1'b1;
      end
      StLocked: fault_o = 1'b1;
      default: ;
    endcase
  end

  assign out_o       = r_out;
  assign out_valid_o = r_v2;
  assign err_cnt_o   = r_err;

endmodule

// File: tb/tb_prim_and2_redundancy_checker.sv
// Bench for prim_and2_redundancy_checker: sticky and non-sticky builds.
// Fault-injection cases need PRIM_AND2_CHK_FI_EN.
module tb_prim_and2_redundancy_checker;
  import prim_and2_chk_pkg::*;

  localparam int W   = 4;
  localparam int THR = 2;
  localparam int M_IDLE = 0;
  localparam int M_SUS  = 1;
  localparam int M_ALR  = 2;
  localparam int M_LCK  = 3;

  logic         clk;
  logic         rst;
  logic         en;
  logic         ack;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic [W-1:0] fi;
  logic [W-1:0] fi_q;
  logic [W-1:0] out_s, out_n;
  logic         vld_s, vld_n;
  logic         req_s, req_n;
  logic         flt_s, flt_n;
  logic [7:0]   err_s, err_n;

  int n_chk = 0;
  int n_err = 0;

  int           m_st [2];
  int           m_cnt[2];
  int           m_err[2];
  bit           m_v1, m_v2, m_mis;
  logic [W-1:0] m_a, m_b, m_out;

  prim_and2_redundancy_checker #(
    .Width(W), .MismatchThresh(THR), .StickyAlert(1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .in0_i       (in0),
    .in1_i       (in1),
`ifdef PRIM_AND2_CHK_FI_EN
    .fi_flip_i   (fi),
`endif
    .out_o       (out_s),
    .out_valid_o (vld_s),
    .alert_req_o (req_s),
    .alert_ack_i (ack),
    .fault_o     (flt_s),
    .err_cnt_o   (err_s)
  );

  prim_and2_redundancy_checker #(
    .Width(W), .MismatchThresh(THR), .StickyAlert(1'b0)
  ) dut0 (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .in0_i       (in0),
    .in1_i       (in1),
`ifdef PRIM_AND2_CHK_FI_EN
    .fi_flip_i   (fi),
`endif
    .out_o       (out_n),
    .out_valid_o (vld_n),
    .alert_req_o (req_n),
    .alert_ack_i (ack),
    .fault_o     (flt_n),
    .err_cnt_o   (err_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] fi_eff();
`ifdef PRIM_AND2_CHK_FI_EN
    return fi;
`else
    return '0;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One valid sample's verdict applied to one FSM/counter instance.
  task automatic step(input int k, input bit sticky);
    bit vm;
    vm = m_v2 && m_mis;
    if (vm && m_err[k] < 255) m_err[k]++;
    case (m_st[k])
      M_IDLE: if (vm) begin
        m_cnt[k] = 1;
        m_st[k]  = (THR == 1) ? M_ALR : M_SUS;
      end
      M_SUS: if (m_v2) begin
        if (m_mis) begin
          m_cnt[k]++;
          if (m_cnt[k] >= THR) m_st[k] = M_ALR;
        end else begin
          m_cnt[k] = 0;
          m_st[k]  = M_IDLE;
        end
      end
      M_ALR: if (ack) begin
        if (sticky) m_st[k] = M_LCK;
        else begin
          m_st[k]  = M_IDLE;
          m_cnt[k] = 0;
        end
      end
      default: ;
    endcase
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_st[k]  = M_IDLE;
        m_cnt[k] = 0;
        m_err[k] = 0;
      end
      m_v1 = 0; m_v2 = 0; m_mis = 0;
      m_a = '0; m_b = '0; m_out = '0;
    end else begin
      step(0, 1'b1);
      step(1, 1'b0);
      if (m_v1) begin
        m_mis = (fi_eff() != '0);
        m_out = m_mis ? '0 : (m_a & m_b);
      end
      m_v2 = m_v1;
      m_v1 = en;
      if (en) begin
        m_a = in0;
        m_b = in1;
      end
    end
  end

  task automatic cmp(input int k, input string tg,
                     input logic [W-1:0] o, input logic v,
                     input logic r, input logic f,
                     input logic [7:0] e);
    chk({tg, ".valid"}, int'(v), int'(m_v2));
    if (m_v2) chk({tg, ".out"}, int'(o), int'(m_out));
    chk({tg, ".req"}, int'(r), int'(m_st[k] == M_ALR));
    chk({tg, ".fault"}, int'(f),
        int'(m_st[k] == M_ALR || m_st[k] == M_LCK));
    chk({tg, ".errcnt"}, int'(e), m_err[k]);
  endtask

  initial forever begin
    @(negedge clk);
    cmp(0, "stk", out_s, vld_s, req_s, flt_s, err_s);
    cmp(1, "nst", out_n, vld_n, req_n, flt_n, err_n);
  end

  // fi belongs to the sample issued one cycle earlier.
  task automatic cyc(input bit e, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] f,
                     input bit k = 1'b0);
    @(negedge clk);
    en   = e;
    in0  = a;
    in1  = b;
    fi   = fi_q;
    fi_q = f;
    ack  = k;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, '0, '0);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; en = 1'b0; ack = 1'b0;
    fi = '0; fi_q = '0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; ack = 1'b0;
    in0 = '0; in1 = '0; fi = '0; fi_q = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.out", int'(out_s), 0);
    chk("rst.valid", int'(vld_s), 0);
    chk("rst.req", int'(req_s), 0);
    chk("rst.fault", int'(flt_s), 0);
    chk("rst.errcnt", int'(err_s), 0);
    rst = 1'b0;

    cyc(1'b1, 4'hC, 4'hA, 4'h0);
    idle(2);
    chk("t1.out", int'(out_s), 8);
    chk("t1.valid", int'(vld_s), 1);
    chk("t1.req", int'(req_s), 0);
    idle(1);
    chk("t1.valid_drop", int'(vld_s), 0);

`ifdef PRIM_AND2_CHK_FI_EN
    cyc(1'b1, 4'hF, 4'hF, 4'h1);
    cyc(1'b1, 4'hF, 4'hF, 4'h0);
    cyc(1'b0, 4'h0, 4'h0, 4'h0);
    chk("t2.out_forced", int'(out_s), 0);
    chk("t2.valid", int'(vld_s), 1);
    cyc(1'b0, 4'h0, 4'h0, 4'h0);
    chk("t2.errcnt", int'(err_s), 1);
    chk("t2.out_clean", int'(out_s), 15);
    chk("t2.suspect", int'(dut.r_state), int'(StSuspect));
    cyc(1'b0, 4'h0, 4'h0, 4'h0);
    chk("t2.idle", int'(dut.r_state), int'(StIdle));
    chk("t2.fault", int'(flt_s), 0);

    cyc(1'b1, 4'hF, 4'hF, 4'h1);
    cyc(1'b1, 4'hF, 4'hF, 4'h1);
    idle(4);
    chk("t3.req", int'(req_s), 1);
    chk("t3.fault", int'(flt_s), 1);
    chk("t3.req_n", int'(req_n), 1);
    chk("t3.errcnt", int'(err_s), 3);
    cyc(1'b0, 4'h0, 4'h0, 4'h0, 1'b1);
    idle(2);
    chk("t3.ack_req", int'(req_s), 0);
    chk("t3.sticky_fault", int'(flt_s), 1);
    chk("t3.nst_fault", int'(flt_n), 0);
    cyc(1'b1, 4'h7, 4'h3, 4'h0);
    idle(4);
    chk("t3.nst_req", int'(req_n), 0);
    chk("t3.nst_err", int'(err_n), 3);
`endif

    pulse_rst();
    cyc(1'b1, 4'h3, 4'h5, 4'h1);
    idle(5);
    cyc(1'b1, 4'h3, 4'h5, 4'h1);
    idle(4);
`ifdef PRIM_AND2_CHK_FI_EN
    chk("t4.gap_req", int'(req_s), 1);
    chk("t4.gap_err", int'(err_s), 2);
`endif

    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5.rst_req", int'(req_s), 0);
    chk("t5.rst_fault", int'(flt_s), 0);
    chk("t5.rst_err", int'(err_s), 0);
    chk("t5.rst_out", int'(out_s), 0);
    @(negedge clk);
    rst = 1'b0; fi = '0; fi_q = '0;

    repeat (300)
      cyc(1'b1, W'($urandom), W'($urandom), 4'h1);
    idle(4);
`ifdef PRIM_AND2_CHK_FI_EN
    chk("t6.sat", int'(err_s), 255);
    chk("t6.sat_n", int'(err_n), 255);
`else
    chk("t6.nofi_err", int'(err_s), 0);
`endif

    pulse_rst();
    for (int i = 0; i < 80; i++) begin
      cyc(bit'($urandom_range(0, 3) != 0),
          W'($urandom), W'($urandom),
          ($urandom_range(0, 5) == 0) ? W'(1 << $urandom_range(0, 3))
                                      : '0,
          bit'($urandom_range(0, 7) == 0));
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
